instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/imem_if.sv | 11 +
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Instruction-memory read port: single-cycle request pulse with word address,
// response qualified by rvalid.
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory read per instruction, holds the
// returned word for decode, handles redirects, stalls and response timeouts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    imem_if.master        imem,
    input  logic          pc_src,
    input  logic [31:0]   pc_target,
    input  logic          stall,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4,
    output logic [6:0]    op,
    output logic [2:0]    funct3,
    output logic          funct7b5,
    output logic          fetch_err,
    output logic          misalign_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic        capture;
    logic        consume;
    logic        timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Responses outside WAIT are stale or duplicates and are simply dropped.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        consume     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            BOOT: state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: begin
                if (imem.rvalid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = REQ;
                end
            end
            HOLD: begin
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            instr        <= '0;
            wait_cnt     <= '0;
            fetch_err    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (state == REQ) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !capture && !timeout_hit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (capture) begin
                instr <= imem.rdata;
            end
            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
            // Misaligned redirect targets are forced onto the word boundary.
            if (consume) begin
                if (pc_src) begin
                    pc <= {pc_target[31:2], 2'b00};
                    if (pc_target[1:0] != 2'b00) begin
                        misalign_err <= 1'b1;
                    end
                end else begin
                    pc <= pc + 32'd4;
                end
            end
        end
    end

    assign imem.req    = (state == REQ);
    assign imem.addr   = pc;
    assign instr_valid = (state == HOLD);
    assign pc_plus4    = pc + 32'd4;
    assign op          = instr_valid ? instr[6:0]   : 7'd0;
    assign funct3      = instr_valid ? instr[14:12] : 3'd0;
    assign funct7b5    = instr_valid ? instr[30]    : 1'b0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scenario tasks with a queue of
// expected {pc, instruction} pairs popped when the unit presents an instruction.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        fetch_err;
    logic        misalign_err;

    imem_if imem ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .stall        (stall),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .fetch_err    (fetch_err),
        .misalign_err (misalign_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one response in the first WAIT cycle; starts in REQ, ends in HOLD.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data);
        exp_t e;
        e.pc   = exp_pc;
        e.data = data;
        sb.push_back(e);
        tick();
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        tick();
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
    endtask

    task automatic test_reset();
        n_assert++;
        if ({imem.req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_req_valid: got req=%b valid=%b, want 0 0", imem.req, instr_valid);
        end
        n_assert++;
        if (pc !== 32'h0 || instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc_instr: got pc=%h instr=%h, want 0 0", pc, instr);
        end
        n_assert++;
        if ({fetch_err, misalign_err, op, funct3, funct7b5} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_flags_decode: got ferr=%b merr=%b op=%h f3=%h f7=%b, want all 0",
                     fetch_err, misalign_err, op, funct3, funct7b5);
        end
        reset = 1'b0;
        tick();
        n_assert++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL boot_to_req: got req=%b addr=%h, want 1 00000000", imem.req, imem.addr);
        end
    endtask

    task automatic test_straight();
        logic [31:0] prog [5];
        logic [31:0] exp_addr;
        exp_t        e;
        int          t_req;
        int          t_prev;
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h4020_8133;
        prog[2] = 32'h0020_C1B3;
        prog[3] = 32'h0031_2223;
        prog[4] = 32'hFE00_0EE3;
        t_prev  = -1;
        for (int k = 0; k < 5; k++) begin
            exp_addr = 32'(4 * k);
            n_assert++;
            if ({imem.req, imem.addr} !== {1'b1, exp_addr}) begin
                n_fail++;
                $display("FAIL straight_req[%0d]: got req=%b addr=%h, want 1 %h", k, imem.req, imem.addr, exp_addr);
            end
            n_assert++;
            if ({instr_valid, op, funct3, funct7b5} !== 12'd0) begin
                n_fail++;
                $display("FAIL straight_invalid_decode[%0d]: got valid=%b op=%h f3=%h f7=%b, want 0", k,
                         instr_valid, op, funct3, funct7b5);
            end
            t_req = cyc;
            do_fetch(exp_addr, prog[k]);
            n_assert++;
            if (instr_valid !== 1'b1 || cyc - t_req !== 2) begin
                n_fail++;
                $display("FAIL straight_latency[%0d]: got valid=%b after %0d cycles, want 1 after 2", k,
                         instr_valid, cyc - t_req);
            end
            if (t_prev >= 0) begin
                n_assert++;
                if (cyc - t_prev !== 3) begin
                    n_fail++;
                    $display("FAIL straight_period[%0d]: got %0d cycles between valids, want 3", k, cyc - t_prev);
                end
            end
            t_prev = cyc;
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL straight_sb[%0d]: got empty scoreboard, want one entry", k);
            end else begin
                e = sb.pop_front();
                n_assert++;
                if ({instr, pc, pc_plus4} !== {e.data, e.pc, e.pc + 32'd4}) begin
                    n_fail++;
                    $display("FAIL straight_data[%0d]: got instr=%h pc=%h pc4=%h, want %h %h %h", k,
                             instr, pc, pc_plus4, e.data, e.pc, e.pc + 32'd4);
                end
                n_assert++;
                if ({op, funct3, funct7b5} !== {e.data[6:0], e.data[14:12], e.data[30]}) begin
                    n_fail++;
                    $display("FAIL straight_decode[%0d]: got op=%h f3=%h f7=%b, want %h %h %b", k,
                             op, funct3, funct7b5, e.data[6:0], e.data[14:12], e.data[30]);
                end
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_branch();
        exp_t e;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0040;
        tick();
        pc_src    = 1'b0;
        pc_target = 32'h0;
        n_assert++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0040}) begin
            n_fail++;
            $display("FAIL branch_req: got req=%b addr=%h, want 1 00000040", imem.req, imem.addr);
        end
        do_fetch(32'h0000_0040, 32'h0080_0113);
        e = sb.pop_front();
        n_assert++;
        if ({instr, pc, pc_plus4} !== {e.data, e.pc, 32'h0000_0044}) begin
            n_fail++;
            $display("FAIL branch_hold: got instr=%h pc=%h pc4=%h, want %h %h 00000044",
                     instr, pc, pc_plus4, e.data, e.pc);
        end
        tick();
    endtask

    task automatic test_stall();
        exp_t e;
        do_fetch(32'h0000_0044, 32'h0050_0093);
        e = sb.pop_front();
        stall       = 1'b1;
        pc_src      = 1'b1;
        pc_target   = 32'h0000_0100;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_assert++;
            if ({imem.req, instr_valid, instr, pc} !== {1'b0, 1'b1, e.data, e.pc} ||
                {op, funct3} !== {7'h13, 3'd0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got req=%b valid=%b instr=%h pc=%h op=%h f3=%h, want 0 1 %h %h 13 0",
                         i, imem.req, instr_valid, instr, pc, op, funct3, e.data, e.pc);
            end
        end
        stall       = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        tick();
        n_assert++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0048}) begin
            n_fail++;
            $display("FAIL stall_release: got req=%b addr=%h, want 1 00000048", imem.req, imem.addr);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   t0;
        n_assert++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got fetch_err=%b, want 0", fetch_err);
        end
        t0 = cyc;
        tick();
        for (int i = 0; i < 20 && imem.req !== 1'b1; i++) tick();
        n_assert++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0048} || cyc - t0 !== 5) begin
            n_fail++;
            $display("FAIL timeout_reissue: got req=%b addr=%h after %0d cycles, want 1 00000048 after 5",
                     imem.req, imem.addr, cyc - t0);
        end
        n_assert++;
        if (fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flag: got fetch_err=%b, want 1", fetch_err);
        end
        do_fetch(32'h0000_0048, 32'h00A0_0513);
        e = sb.pop_front();
        n_assert++;
        if ({instr, pc, fetch_err} !== {e.data, e.pc, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_recover: got instr=%h pc=%h ferr=%b, want %h %h 1",
                     instr, pc, fetch_err, e.data, e.pc);
        end
    endtask

    task automatic test_misalign_wrap();
        exp_t e;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0022;
        tick();
        n_assert++;
        if ({imem.req, imem.addr, misalign_err} !== {1'b1, 32'h0000_0020, 1'b1}) begin
            n_fail++;
            $display("FAIL misalign: got req=%b addr=%h merr=%b, want 1 00000020 1",
                     imem.req, imem.addr, misalign_err);
        end
        pc_src    = 1'b0;
        pc_target = 32'h0;
        do_fetch(32'h0000_0020, 32'h0000_0013);
        e = sb.pop_front();
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        tick();
        pc_src    = 1'b0;
        pc_target = 32'h0;
        n_assert++;
        if ({imem.req, imem.addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_req: got req=%b addr=%h, want 1 fffffffc", imem.req, imem.addr);
        end
        do_fetch(32'hFFFF_FFFC, 32'h0010_0073);
        e = sb.pop_front();
        n_assert++;
        if ({instr, pc, pc_plus4} !== {e.data, e.pc, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_hold: got instr=%h pc=%h pc4=%h, want %h %h 00000000",
                     instr, pc, pc_plus4, e.data, e.pc);
        end
        tick();
        n_assert++;
        if ({imem.req, imem.addr, misalign_err, fetch_err} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_next: got req=%b addr=%h merr=%b ferr=%b, want 1 00000000 1 1",
                     imem.req, imem.addr, misalign_err, fetch_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_assert++;
        if ({imem.req, instr_valid, pc, instr, fetch_err, misalign_err} !== {2'b00, 32'h0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL midwait_reset: got req=%b valid=%b pc=%h instr=%h ferr=%b merr=%b, want all 0",
                     imem.req, instr_valid, pc, instr, fetch_err, misalign_err);
        end
        reset       = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        tick();
        n_assert++;
        if ({imem.req, imem.addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL midwait_first_req: got req=%b addr=%h valid=%b, want 1 00000000 0",
                     imem.req, imem.addr, instr_valid);
        end
        tick();
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        e.pc   = 32'h0;
        e.data = 32'h0030_0193;
        sb.push_back(e);
        n_assert++;
        if ({imem.req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midwait_stale_dropped: got req=%b valid=%b, want 0 0", imem.req, instr_valid);
        end
        tick();
        n_assert++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_still_waiting: got valid=%b, want 0", instr_valid);
        end
        imem.rvalid = 1'b1;
        imem.rdata  = e.data;
        tick();
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        e = sb.pop_front();
        n_assert++;
        if ({instr_valid, instr, pc, fetch_err, misalign_err} !== {1'b1, e.data, e.pc, 2'b00}) begin
            n_fail++;
            $display("FAIL midwait_capture: got valid=%b instr=%h pc=%h ferr=%b merr=%b, want 1 %h %h 0 0",
                     instr_valid, instr, pc, fetch_err, misalign_err, e.data, e.pc);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        stall       = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        tick();
        tick();
        test_reset();
        test_straight();
        test_branch();
        test_stall();
        test_timeout();
        test_misalign_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
